answer_period_timer: RTL and testbench
======================================

Name: answer_period_timer

Overview:
Parametrised answer-window timer for the game controller. The block runs entirely in the Clk100M domain and derives its seconds tick internally from a prescaler. After a start request it counts down a configurable answer window. The window ends on the first player buzz-in or on timeout; the block then reports the winner and drives a four-digit seven-segment readout with the countdown and the result.

Parameters:
CLK_HZ, 100000000, Clk100M cycles per second tick (>=2; benches use small values)
PERIOD_SEC, 5, answer window length in seconds (1..99)
NUM_PLAYERS, 4, number of buzzer inputs (1..9)

Ports:
Clk100M  input  1  system clock; all logic on rising edge
Reset  input  1  asynchronous, active-high reset
answerSig  input  1  start request; acted on at its rising edge only
buzzIn  input  NUM_PLAYERS  player buzzers, level, bit i = player i
postSig  output  1  one-cycle pulse when the window ends (buzz or timeout)
stopCount  output  1  one-cycle pulse, coincident with postSig
running  output  1  high while the window is open
timedOut  output  1  result flag: window ended with no buzz; held until next start
winner  output  4  index of the winning player; 0 on timeout; held until next start
answerSeg0  output  8  ones digit of remaining seconds
answerSeg1  output  8  tens digit of remaining seconds
answerSeg2  output  8  reserved, always 0x00
answerSeg3  output  8  result digit

Behaviour:
- Reset (async, immediate): state=IDLE, prescaler=0, remaining=0, edge register=0. All outputs are 0, including every answerSeg (0x00 = blank).
- Segment encoding, 1 = lit: bit0=a .. bit6=g, bit7=dp (always 0).
  - Digits: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Blank=0x00; dash=0x40.
- Start detection: startPulse = answerSig & ~answerSig_q, where answerSig_q is the previous-cycle value. A level held high does not re-trigger.
- States:
  - IDLE: on startPulse -> RUN. Load remaining=PERIOD_SEC, prescaler=0, timedOut=0, winner=0.
  - RUN:
    - running=1. prescaler counts 0..CLK_HZ-1 and wraps.
    - On wrap (tick), remaining decrements.
    - On a tick with remaining==1 -> DONE with timedOut=1, winner=0, remaining=0.
    - If any buzzIn bit is high -> DONE with winner = lowest set index, timedOut=0, remaining frozen.
    - Buzz and final tick in the same cycle: the buzz wins (timedOut=0).
    - startPulse in RUN is ignored.
  - DONE:
    - postSig=stopCount=1 only in the first DONE cycle (registered, asserted on the same edge that enters DONE).
    - Results and display are held; buzzIn is ignored.
    - startPulse -> RUN with a fresh load.
- buzzIn is ignored in IDLE and DONE.
- Timing: startPulse sampled at edge N gives RUN from N+1. The first decrement is at edge N+CLK_HZ. Timeout enters DONE at edge N+PERIOD_SEC*CLK_HZ.
- Display: registered, derived from the registered state and remaining, so it lags by one cycle.
  - IDLE: all blank.
  - RUN/DONE: answerSeg0 = ones digit of remaining; answerSeg1 = tens digit, blank when the tens digit is 0.
  - answerSeg3: blank in RUN; dash on timeout; digit (winner+1) on a buzz.
  - BCD split is by comparison/subtraction on the 7-bit remaining value; no division operator.
- Widths: prescaler is $clog2(CLK_HZ) bits; remaining is 7 bits. Width mismatches are not permitted.

Test Plan:
(CLK_HZ=10, PERIOD_SEC=3, NUM_PLAYERS=4 unless noted)
1. Timeout: answerSig rises, sampled at edge 0 -> running from edge 1; remaining 3->2 at edge 10, ->1 at edge 20; DONE at edge 30. postSig=stopCount=1 for exactly that cycle; timedOut=1, winner=0. Next cycle: seg0=0x3F, seg1=0x00, seg3=0x40.
2. Buzz: buzzIn=4'b0110 at edge 15 -> DONE, winner=1, timedOut=0, one postSig pulse. Then seg3=0x5B, seg0=0x5B (remaining 2 frozen). Later buzzIn changes leave results unchanged.
3. Simultaneous: buzzIn=4'b1000 asserted on the final-tick cycle -> winner=3, timedOut=0, seg3=0x66, single pulse.
4. Re-arm: answerSig held high through DONE -> no restart. Drop then re-raise it -> RUN, remaining=3, timedOut/winner cleared. A second answerSig rise during RUN does not reset the countdown.
5. Reset mid-RUN at edge 12 -> immediately IDLE, all outputs 0, no postSig pulse. A later start behaves as in scenario 1.
6. PERIOD_SEC=12: after start, seg1=0x06, seg0=0x5B. When remaining=9, seg1=0x00 (blank) and seg0=0x6F.

Source files
------------

// File: rtl/answer_period_timer_if.sv
// Handshake bundle between the game controller and the answer-window timer.
interface answer_period_timer_if #(
    parameter int NUM_PLAYERS = 4
);
    logic                   answerSig;
    logic [NUM_PLAYERS-1:0] buzzIn;
    logic                   postSig;
    logic                   stopCount;
    logic                   running;
    logic                   timedOut;
    logic [3:0]             winner;
    logic [7:0]             answerSeg0;
    logic [7:0]             answerSeg1;
    logic [7:0]             answerSeg2;
    logic [7:0]             answerSeg3;

    modport master (
        output answerSig, buzzIn,
        input  postSig, stopCount, running, timedOut, winner,
        input  answerSeg0, answerSeg1, answerSeg2, answerSeg3
    );

    modport slave (
        input  answerSig, buzzIn,
        output postSig, stopCount, running, timedOut, winner,
        output answerSeg0, answerSeg1, answerSeg2, answerSeg3
    );
endinterface

// File: rtl/answer_period_timer.sv
// Answer-window countdown: opens on a start edge, closes on first buzz or timeout,
// and shows remaining seconds plus the result on a four-digit seven-segment readout.
module answer_period_timer #(
    parameter int CLK_HZ      = 100000000,
    parameter int PERIOD_SEC  = 5,
    parameter int NUM_PLAYERS = 4
) (
    input  logic                 Clk100M,
    input  logic                 Reset,
    answer_period_timer_if.slave bus
);
    localparam int              PW          = $clog2(CLK_HZ);
    localparam logic [PW-1:0]   PRESC_LAST  = PW'(CLK_HZ - 1);
    localparam logic [6:0]      PERIOD_LOAD = 7'(PERIOD_SEC);
    localparam logic [7:0]      SEG_BLANK   = 8'h00;
    localparam logic [7:0]      SEG_DASH    = 8'h40;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          answer_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    rem_q, rem_d;
    logic          timed_q, timed_d;
    logic [3:0]    winner_q, winner_d;
    logic          post_q, post_d;
    logic          running_q, running_d;
    logic [7:0]    seg0_q, seg0_d, seg1_q, seg1_d, seg3_q, seg3_d;
    logic          start_s, tick_s, buzz_any_s;
    logic [7:0]    split_s;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Returns {tens, ones}; the largest multiple of ten not above v wins.
    function automatic logic [7:0] bcd_split(input logic [6:0] v);
        logic [3:0] tens;
        logic [6:0] ones;
        tens = 4'd0;
        ones = v;
        for (int t = 1; t <= 9; t++) begin
            if (v >= 7'(t * 10)) begin
                tens = 4'(t);
                ones = v - 7'(t * 10);
            end else begin
                tens = tens;
                ones = ones;
            end
        end
        return {tens, ones[3:0]};
    endfunction

    function automatic logic [3:0] lowest_idx(input logic [NUM_PLAYERS-1:0] b);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (b[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign start_s    = bus.answerSig & ~answer_q;
    assign tick_s     = (presc_q == PRESC_LAST);
    assign buzz_any_s = |bus.buzzIn;
    assign split_s    = bcd_split(rem_q);

    // Window control: next state, countdown and result capture.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        rem_d    = rem_q;
        timed_d  = timed_q;
        winner_d = winner_q;
        post_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_s) begin
                    state_d  = RUN;
                    presc_d  = {PW{1'b0}};
                    rem_d    = PERIOD_LOAD;
                    timed_d  = 1'b0;
                    winner_d = 4'd0;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                // A buzz beats a simultaneous final tick and freezes the count.
                if (buzz_any_s) begin
                    state_d  = DONE;
                    winner_d = lowest_idx(bus.buzzIn);
                    timed_d  = 1'b0;
                    post_d   = 1'b1;
                end else if (tick_s) begin
                    presc_d = {PW{1'b0}};
                    if (rem_q == 7'd1) begin
                        state_d  = DONE;
                        timed_d  = 1'b1;
                        winner_d = 4'd0;
                        rem_d    = 7'd0;
                        post_d   = 1'b1;
                    end else begin
                        rem_d = rem_q - 7'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        running_d = (state_d == RUN);
    end

    // Display decode from registered state, one cycle behind the count.
    always_comb begin
        seg0_d = SEG_BLANK;
        seg1_d = SEG_BLANK;
        seg3_d = SEG_BLANK;
        case (state_q)
            RUN, DONE: begin
                seg0_d = seg7(split_s[3:0]);
                if (split_s[7:4] == 4'd0) begin
                    seg1_d = SEG_BLANK;
                end else begin
                    seg1_d = seg7(split_s[7:4]);
                end
                if (state_q != DONE) begin
                    seg3_d = SEG_BLANK;
                end else if (timed_q) begin
                    seg3_d = SEG_DASH;
                end else begin
                    seg3_d = seg7(winner_q + 4'd1);
                end
            end
            default: begin
                seg0_d = SEG_BLANK;
            end
        endcase
    end

    // State, counters, results and display registers.
    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            answer_q  <= 1'b0;
            presc_q   <= {PW{1'b0}};
            rem_q     <= 7'd0;
            timed_q   <= 1'b0;
            winner_q  <= 4'd0;
            post_q    <= 1'b0;
            running_q <= 1'b0;
            seg0_q    <= 8'h00;
            seg1_q    <= 8'h00;
            seg3_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            answer_q  <= bus.answerSig;
            presc_q   <= presc_d;
            rem_q     <= rem_d;
            timed_q   <= timed_d;
            winner_q  <= winner_d;
            post_q    <= post_d;
            running_q <= running_d;
            seg0_q    <= seg0_d;
            seg1_q    <= seg1_d;
            seg3_q    <= seg3_d;
        end
    end

    assign bus.postSig    = post_q;
    assign bus.stopCount  = post_q;
    assign bus.running    = running_q;
    assign bus.timedOut   = timed_q;
    assign bus.winner     = winner_q;
    assign bus.answerSeg0 = seg0_q;
    assign bus.answerSeg1 = seg1_q;
    assign bus.answerSeg2 = 8'h00;
    assign bus.answerSeg3 = seg3_q;
endmodule

// File: tb/tb_answer_period_timer.sv
// Bench for answer_period_timer: vector table for window outcomes, scoreboard of
// expected results popped on each postSig, and hand sequences for re-arm and reset.
module tb_answer_period_timer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    answer_period_timer_if #(.NUM_PLAYERS(4)) b();
    answer_period_timer_if #(.NUM_PLAYERS(4)) b12();

    answer_period_timer #(.CLK_HZ(10), .PERIOD_SEC(3), .NUM_PLAYERS(4)) dut (
        .Clk100M(clk), .Reset(rst), .bus(b.slave));
    answer_period_timer #(.CLK_HZ(10), .PERIOD_SEC(12), .NUM_PLAYERS(4)) dut12 (
        .Clk100M(clk), .Reset(rst), .bus(b12.slave));

    typedef struct {
        logic [3:0] winner;
        logic       timed;
    } res_t;

    typedef struct {
        logic [3:0] bval;
        int         bedge;
        int         exp_edge;
        logic [3:0] exp_win;
        logic       exp_to;
        logic [7:0] exp_seg0;
        logic [7:0] exp_seg3;
    } vec_t;

    res_t sbq[$];
    res_t r_m;
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_err = 0;
    int   pe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_post"},    32'(b.postSig),    32'd0);
        check({tag, "_stop"},    32'(b.stopCount),  32'd0);
        check({tag, "_running"}, 32'(b.running),    32'd0);
        check({tag, "_timed"},   32'(b.timedOut),   32'd0);
        check({tag, "_winner"},  32'(b.winner),     32'd0);
        check({tag, "_seg0"},    32'(b.answerSeg0), 32'd0);
        check({tag, "_seg1"},    32'(b.answerSeg1), 32'd0);
        check({tag, "_seg2"},    32'(b.answerSeg2), 32'd0);
        check({tag, "_seg3"},    32'(b.answerSeg3), 32'd0);
    endtask

    task automatic do_start(input bit hold);
        b.answerSig = 1'b1;
        step();
        if (!hold) b.answerSig = 1'b0;
    endtask

    // Runs edges 1..40 after the start edge; returns the edge where postSig showed, or -1.
    task automatic run_window(input logic [3:0] bval, input int bedge, input int rearm,
                              output int post_edge);
        post_edge = -1;
        for (int e = 1; e <= 40; e++) begin
            if (e == bedge) b.buzzIn = bval;
            if (rearm > 0 && e == rearm) b.answerSig = 1'b0;
            if (rearm > 0 && e == rearm + 1) b.answerSig = 1'b1;
            if (rearm > 0 && e == rearm + 2) b.answerSig = 1'b0;
            step();
            if (b.postSig === 1'b1) begin
                post_edge = e;
                break;
            end
        end
    endtask

    // Scoreboard: every postSig pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (b.postSig === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_post: postSig=1, expected no pulse");
            end else begin
                r_m = sbq.pop_front();
                check("sb_winner", 32'(b.winner), 32'(r_m.winner));
                check("sb_timed", 32'(b.timedOut), 32'(r_m.timed));
                check("sb_stop", 32'(b.stopCount), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0000,  0, 30, 4'd0, 1'b1, 8'h3F, 8'h40};
        vecs[1] = '{4'b0110, 15, 15, 4'd1, 1'b0, 8'h5B, 8'h5B};
        vecs[2] = '{4'b1000, 30, 30, 4'd3, 1'b0, 8'h06, 8'h66};
        vecs[3] = '{4'b0001,  1,  1, 4'd0, 1'b0, 8'h4F, 8'h06};
        vecs[4] = '{4'b1111, 29, 29, 4'd0, 1'b0, 8'h06, 8'h06};
        vecs[5] = '{4'b0100, 25, 25, 4'd2, 1'b0, 8'h06, 8'h4F};

        rst = 1'b1;
        b.answerSig = 1'b0;
        b.buzzIn = 4'b0000;
        b12.answerSig = 1'b0;
        b12.buzzIn = 4'b0000;
        step();
        step();
        check_all_zero("reset");
        #2 rst = 1'b0;
        step();

        // Two-digit window: 12 shows as "12", 9 shows with a blank tens digit.
        b12.answerSig = 1'b1;
        step();
        b12.answerSig = 1'b0;
        step();
        step();
        check("p12_running", 32'(b12.running), 32'd1);
        check("p12_seg1_12", 32'(b12.answerSeg1), 32'h06);
        check("p12_seg0_12", 32'(b12.answerSeg0), 32'h5B);
        repeat (29) step();
        check("p12_seg1_9", 32'(b12.answerSeg1), 32'h00);
        check("p12_seg0_9", 32'(b12.answerSeg0), 32'h6F);

        for (int i = 0; i < 6; i++) begin
            sbq.push_back('{vecs[i].exp_win, vecs[i].exp_to});
            do_start(1'b0);
            run_window(vecs[i].bval, vecs[i].bedge, 0, pe);
            check("post_edge", 32'(pe), 32'(vecs[i].exp_edge));
            step();
            check("post_single", 32'(b.postSig), 32'd0);
            check("stop_single", 32'(b.stopCount), 32'd0);
            check("running_done", 32'(b.running), 32'd0);
            check("seg0_done", 32'(b.answerSeg0), 32'(vecs[i].exp_seg0));
            check("seg1_done", 32'(b.answerSeg1), 32'h00);
            check("seg2_done", 32'(b.answerSeg2), 32'h00);
            check("seg3_done", 32'(b.answerSeg3), 32'(vecs[i].exp_seg3));
            if (vecs[i].bval != 4'b0000) begin
                b.buzzIn = ~vecs[i].bval;
                repeat (3) step();
                check("winner_held", 32'(b.winner), 32'(vecs[i].exp_win));
                check("timed_held", 32'(b.timedOut), 32'(vecs[i].exp_to));
                check("seg3_held", 32'(b.answerSeg3), 32'(vecs[i].exp_seg3));
                b.buzzIn = 4'b0000;
            end
        end

        // Re-arm from a buzz result with answerSig held high through the timeout.
        sbq.push_back('{4'd0, 1'b1});
        do_start(1'b1);
        check("rearm_running", 32'(b.running), 32'd1);
        check("rearm_winner_clr", 32'(b.winner), 32'd0);
        run_window(4'b0000, 0, 0, pe);
        check("rearm_post_edge", 32'(pe), 32'd30);
        repeat (5) step();
        check("held_no_restart", 32'(b.running), 32'd0);
        check("held_timed", 32'(b.timedOut), 32'd1);
        b.answerSig = 1'b0;
        step();
        sbq.push_back('{4'd0, 1'b1});
        do_start(1'b0);
        check("restart_running", 32'(b.running), 32'd1);
        check("restart_timed_clr", 32'(b.timedOut), 32'd0);
        step();
        check("restart_seg0", 32'(b.answerSeg0), 32'h4F);
        check("restart_seg3", 32'(b.answerSeg3), 32'h00);
        run_window(4'b0000, 0, 7, pe);
        check("ignore_restart_edge", 32'(pe + 1), 32'd30);

        // Asynchronous reset in the middle of a window.
        step();
        do_start(1'b0);
        repeat (11) step();
        check("mid_running", 32'(b.running), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        step();
        #2 rst = 1'b0;
        step();
        check_all_zero("after_rst");
        sbq.push_back('{4'd0, 1'b1});
        do_start(1'b0);
        run_window(4'b0000, 0, 0, pe);
        check("post_rst_edge", 32'(pe), 32'd30);
        step();
        check("post_rst_seg3", 32'(b.answerSeg3), 32'h40);
        check("post_rst_seg0", 32'(b.answerSeg0), 32'h3F);

        step();
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
